win_block_receiver: RTL and testbench

- Core-side receiving end of the window loader stream.
- The loader broadcasts window blocks (WINDOW_BLOCKING elements per beat), each tagged with a processor offset, a row and a block index.
- Each instance captures only the beats tagged with its own PROC_OFFSET into a local window buffer, counts them against the expected total for the announced window size, raises done, and serves the core's random reads until the core releases the buffer.

---
 rtl/win_block_receiver_if.sv | 37 +++
 rtl/win_block_receiver.sv | 88 ++++++++
 tb/tb_win_block_receiver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/win_block_receiver_if.sv
// win_block_receiver_if: window loader stream, status and core read port for one receiver
//   master : loader/core side, drives start, size, stream beats, reads and release
//   slave  : receiver side, returns ld_ready, idle, win_done, err and rd_data
interface win_block_receiver_if #(
   parameter int OFF_BITS        = 1,
   parameter int WIN_BITS        = 5,
   parameter int BLK_BITS        = 3,
   parameter int WINDOW_BLOCKING = 4,
   parameter int ELEM_WIDTH      = 32
);
   logic                                  start_i;
   logic [WIN_BITS-1:0]                   win_size_i;
   logic                                  ld_valid_i;
   logic                                  ld_ready_o;
   logic [OFF_BITS-1:0]                   ld_offset_i;
   logic [WIN_BITS-1:0]                   ld_row_i;
   logic [BLK_BITS-1:0]                   ld_blk_i;
   logic [WINDOW_BLOCKING*ELEM_WIDTH-1:0] ld_data_i;
   logic                                  idle_o;
   logic                                  win_done_o;
   logic                                  err_o;
   logic                                  rd_en_i;
   logic [WIN_BITS-1:0]                   rd_row_i;
   logic [BLK_BITS-1:0]                   rd_blk_i;
   logic [WINDOW_BLOCKING*ELEM_WIDTH-1:0] rd_data_o;
   logic                                  release_i;
   modport master (
      output start_i, win_size_i, ld_valid_i, ld_offset_i, ld_row_i, ld_blk_i, ld_data_i,
             rd_en_i, rd_row_i, rd_blk_i, release_i,
      input  ld_ready_o, idle_o, win_done_o, err_o, rd_data_o
   );
   modport slave (
      input  start_i, win_size_i, ld_valid_i, ld_offset_i, ld_row_i, ld_blk_i, ld_data_i,
             rd_en_i, rd_row_i, rd_blk_i, release_i,
      output ld_ready_o, idle_o, win_done_o, err_o, rd_data_o
   );
endinterface

// File: rtl/win_block_receiver.sv
// win_block_receiver: captures the stream beats tagged with PROC_OFFSET into a local window buffer
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of win_block_receiver_if (start/size, stream beats, status, read port, release)
module win_block_receiver #(
   parameter int PROC_OFFSET      = 0,
   parameter int NUM_PROC_OFFSETS = 2,
   parameter int OFF_BITS         = 1,
   parameter int WINDOW_BLOCKING  = 4,
   parameter int ELEM_WIDTH       = 32,
   parameter int MAX_WIN          = 24,
   parameter int WIN_BITS         = 5,
   parameter int BLK_BITS         = 3
) (
   input logic                  clk,
   input logic                  rst,
   win_block_receiver_if.slave  bus
);
   // Row stride is fixed by the largest window so addresses never depend on win_size.
   localparam int STRIDE = (MAX_WIN + WINDOW_BLOCKING - 1) / WINDOW_BLOCKING;
   localparam int DEPTH  = MAX_WIN * STRIDE;
   localparam int AW     = $clog2(((1 << WIN_BITS) - 1) * STRIDE + (1 << BLK_BITS));
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int DW     = WINDOW_BLOCKING * ELEM_WIDTH;
   typedef enum logic [1:0] {S_READY, S_FILLING, S_DONE} state_t;
   state_t              state_q;
   logic [WIN_BITS-1:0] size_q;
   logic [BLK_BITS-1:0] bpr_q, bpr_d;
   logic [CW-1:0]       cnt_q, expect_q, expect_d;
   logic                err_q;
   logic [DW-1:0]       rd_data_q;
   logic [DW-1:0]       mem [DEPTH];
   logic                size_ok, hit, in_range, wr;
   logic [AW-1:0]       wr_addr, rd_addr;
   always_comb begin
      bpr_d    = BLK_BITS'((int'(bus.win_size_i) + WINDOW_BLOCKING - 1) / WINDOW_BLOCKING);
      expect_d = CW'(int'(bus.win_size_i) * int'(bpr_d));
      size_ok  = bus.win_size_i != '0 && int'(bus.win_size_i) <= MAX_WIN;
      hit      = state_q == S_FILLING && bus.ld_valid_i &&
                 bus.ld_offset_i == OFF_BITS'(PROC_OFFSET % NUM_PROC_OFFSETS);
      in_range = bus.ld_row_i < size_q && bus.ld_blk_i < bpr_q;
      wr       = hit && in_range;
      wr_addr  = AW'(bus.ld_row_i) * AW'(STRIDE) + AW'(bus.ld_blk_i);
      rd_addr  = AW'(bus.rd_row_i) * AW'(STRIDE) + AW'(bus.rd_blk_i);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_READY;
         size_q    <= '0;
         bpr_q     <= '0;
         cnt_q     <= '0;
         expect_q  <= '0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         if (bus.rd_en_i) rd_data_q <= mem[rd_addr];
         case (state_q)
            S_READY: if (bus.start_i) begin
               if (size_ok) begin
                  size_q   <= bus.win_size_i;
                  bpr_q    <= bpr_d;
                  expect_q <= expect_d;
                  cnt_q    <= '0;
                  err_q    <= 1'b0;
                  state_q  <= S_FILLING;
               end else err_q <= 1'b1;
            end
            S_FILLING: begin
               // Foreign offsets are silently skipped; only our own out-of-range beats are errors.
               if (hit && !in_range) err_q <= 1'b1;
               if (wr) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q + 1'b1 == expect_q) state_q <= S_DONE;
               end
            end
            S_DONE: if (bus.release_i) state_q <= S_READY;
            default: state_q <= S_READY;
         endcase
      end
   end
   // Buffer has no reset so it maps onto plain RAM; a same-cycle read sees the old word.
   always_ff @(posedge clk) if (wr) mem[wr_addr] <= bus.ld_data_i;
   // Status is decoded from state alone so ld_ready can be ANDed across receivers.
   assign bus.ld_ready_o = state_q == S_FILLING;
   assign bus.idle_o     = state_q == S_READY;
   assign bus.win_done_o = state_q == S_DONE;
   assign bus.err_o      = err_q;
   assign bus.rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_win_block_receiver.sv
// tb_win_block_receiver: directed checks of capture, counting, errors, release and read port
module tb_win_block_receiver;
   localparam int DW = 128;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   win_block_receiver_if #(.OFF_BITS(1), .WIN_BITS(5), .BLK_BITS(3), .WINDOW_BLOCKING(4), .ELEM_WIDTH(32)) bus ();
   win_block_receiver #(.PROC_OFFSET(0), .NUM_PROC_OFFSETS(2), .OFF_BITS(1), .WINDOW_BLOCKING(4),
                        .ELEM_WIDTH(32), .MAX_WIN(24), .WIN_BITS(5), .BLK_BITS(3))
      dut (.clk(clk), .rst(rst), .bus(bus));
   function automatic logic [DW-1:0] pay(int tag, int row, int blk);
      return {4{8'(tag), 8'(row), 8'(blk), 8'hC3}};
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_flags(string tag, logic idle, logic rdy, logic done, logic err);
      chk({tag, ".idle"}, DW'(bus.idle_o), DW'(idle));
      chk({tag, ".ld_ready"}, DW'(bus.ld_ready_o), DW'(rdy));
      chk({tag, ".win_done"}, DW'(bus.win_done_o), DW'(done));
      chk({tag, ".err"}, DW'(bus.err_o), DW'(err));
   endtask
   task automatic beat(int off, int row, int blk, logic [DW-1:0] d);
      bus.ld_valid_i  = 1'b1;
      bus.ld_offset_i = 1'(off);
      bus.ld_row_i    = 5'(row);
      bus.ld_blk_i    = 3'(blk);
      bus.ld_data_i   = d;
      tick();
      bus.ld_valid_i  = 1'b0;
   endtask
   task automatic start(int sz);
      bus.win_size_i = 5'(sz);
      bus.start_i    = 1'b1;
      tick();
      bus.start_i    = 1'b0;
   endtask
   task automatic rel;
      bus.release_i = 1'b1;
      tick();
      bus.release_i = 1'b0;
   endtask
   task automatic rd(int row, int blk);
      bus.rd_en_i  = 1'b1;
      bus.rd_row_i = 5'(row);
      bus.rd_blk_i = 3'(blk);
      tick();
      bus.rd_en_i  = 1'b0;
   endtask
   initial begin
      bus.start_i = 1'b0; bus.win_size_i = '0; bus.ld_valid_i = 1'b0; bus.ld_offset_i = '0;
      bus.ld_row_i = '0; bus.ld_blk_i = '0; bus.ld_data_i = '0; bus.rd_en_i = 1'b0;
      bus.rd_row_i = '0; bus.rd_blk_i = '0; bus.release_i = 1'b0;
      repeat (2) tick();
      chk_flags("reset", 1, 0, 0, 0);
      chk("reset.rd_data", bus.rd_data_o, '0);
      rst = 1'b0;
      tick();
      // 8x8 window, own beats interleaved with offset-1 beats to the same addresses
      start(8);
      chk_flags("w8.start", 0, 1, 0, 0);
      for (int r = 0; r < 8; r++)
         for (int b = 0; b < 2; b++) begin
            if (r * 2 + b == 15) chk_flags("w8.pre_done", 0, 1, 0, 0);
            beat(0, r, b, pay(1, r, b));
            if (r * 2 + b < 15) beat(1, r, b, pay(9, r, b));
         end
      chk_flags("w8.done", 0, 0, 1, 0);
      rd(3, 1);
      chk("w8.rd31", bus.rd_data_o, pay(1, 3, 1));
      tick();
      chk("w8.rd31_hold", bus.rd_data_o, pay(1, 3, 1));
      rd(7, 0);
      chk("w8.rd70", bus.rd_data_o, pay(1, 7, 0));
      // start together with release in S_Done is ignored
      bus.win_size_i = 5'd8;
      bus.start_i = 1'b1;
      bus.release_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      bus.release_i = 1'b0;
      chk_flags("rel_start", 1, 0, 0, 0);
      tick();
      chk_flags("rel_start.after", 1, 0, 0, 0);
      // illegal sizes
      start(0);
      chk_flags("sz0", 1, 0, 0, 1);
      start(4);
      chk_flags("w4.start", 0, 1, 0, 0);
      for (int r = 0; r < 4; r++) begin
         if (r == 3) chk_flags("w4.pre_done", 0, 1, 0, 0);
         beat(0, r, 0, pay(4, r, 0));
      end
      chk_flags("w4.done", 0, 0, 1, 0);
      rel();
      chk_flags("w4.released", 1, 0, 0, 0);
      start(25);
      chk_flags("sz25", 1, 0, 0, 1);
      // 5x5 window: out-of-range beats, same-cycle write/read
      start(5);
      chk_flags("w5.start", 0, 1, 0, 0);
      beat(0, 5, 0, pay(7, 5, 0));
      chk_flags("w5.bad_row", 0, 1, 0, 1);
      beat(0, 0, 2, pay(7, 0, 2));
      chk_flags("w5.bad_blk", 0, 1, 0, 1);
      for (int r = 0; r < 5; r++)
         for (int b = 0; b < 2; b++) begin
            if (r * 2 + b == 9) chk_flags("w5.pre_done", 0, 1, 0, 1);
            if (r == 2 && b == 0) begin
               bus.rd_en_i = 1'b1;
               bus.rd_row_i = 5'd2;
               bus.rd_blk_i = 3'd0;
            end
            beat(0, r, b, pay(5, r, b));
            if (r == 2 && b == 0) begin
               bus.rd_en_i = 1'b0;
               chk("w5.rw_old", bus.rd_data_o, pay(4, 2, 0));
            end
         end
      chk_flags("w5.done", 0, 0, 1, 1);
      rd(2, 0);
      chk("w5.rw_new", bus.rd_data_o, pay(5, 2, 0));
      rd(5, 0);
      chk("w5.bad_row_not_written", bus.rd_data_o, pay(1, 5, 0));
      // valid held while not ready must not write
      bus.ld_valid_i = 1'b1;
      bus.ld_offset_i = 1'b0;
      bus.ld_row_i = 5'd0;
      bus.ld_blk_i = 3'd0;
      bus.ld_data_i = pay(7, 0, 0);
      repeat (2) tick();
      rel();
      tick();
      bus.ld_valid_i = 1'b0;
      rd(0, 0);
      chk("hold_valid.rd00", bus.rd_data_o, pay(5, 0, 0));
      chk_flags("hold_valid.ready", 1, 0, 0, 1);
      // asynchronous reset mid-fill, then a full recount
      start(8);
      for (int i = 0; i < 5; i++) beat(0, i / 2, i % 2, pay(2, i / 2, i % 2));
      #2 rst = 1'b1;
      #1;
      chk_flags("rst_mid", 1, 0, 0, 0);
      chk("rst_mid.rd_data", bus.rd_data_o, '0);
      tick();
      rst = 1'b0;
      start(8);
      chk_flags("w8b.start", 0, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk_flags("w8b.pre_done", 0, 1, 0, 0);
         beat(0, i / 2, i % 2, pay(3, i / 2, i % 2));
      end
      chk_flags("w8b.done", 0, 0, 1, 0);
      rd(6, 1);
      chk("w8b.rd61", bus.rd_data_o, pay(3, 6, 1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
